// File: rtl/pc_npc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_npc_sequencer
//
// Program-counter sequencer for the SPARC datapath. Holds the architectural
// PC/nPC pair and applies delayed-branch semantics (including annul), JMPL
// linking, and a small LIFO trap stack that saves PC/nPC pairs across nested
// traps and restores them on RETRY/DONE.
//
// Parameters:
//   ADDR_W       width of PC, nPC and all address ports
//   INST_BYTES   increment per instruction (power of two)
//   RESET_VECTOR PC value after reset; nPC resets to RESET_VECTOR+INST_BYTES
//   DEPTH        number of trap-stack entries (>= 1)
//
// Ports:
//   Clk          clock, all state updates on the rising edge
//   RESET_n      asynchronous active-low reset
//   advance      apply op this cycle; when low, all state holds
//   op           000 SEQ, 001 BR, 010 JMPL, 011 TRAP, 100 RETRY, 101 DONE
//                (110/111 behave as SEQ)
//   cond_taken   branch condition result (BR only)
//   annul        branch annul bit (BR only)
//   target       branch/JMPL destination
//   trap_vec     trap handler address
//   pc, npc      current PC / nPC
//   link_pc      PC captured by the last JMPL
//   depth        number of valid trap-stack entries
//   stack_full   depth == DEPTH (combinational)
//   stack_empty  depth == 0 (combinational)
//   err_mode     sticky, set by a trap taken with the stack full
//   misalign     one-cycle pulse: used target/trap_vec had low bits set
//   underflow    one-cycle pulse: RETRY/DONE with an empty stack
// -----------------------------------------------------------------------------
module pc_npc_sequencer #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_BYTES = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       Clk,
  input  logic                       RESET_n,
  input  logic                       advance,
  input  logic [2:0]                 op,
  input  logic                       cond_taken,
  input  logic                       annul,
  input  logic [ADDR_W-1:0]          target,
  input  logic [ADDR_W-1:0]          trap_vec,
  output logic [ADDR_W-1:0]          pc,
  output logic [ADDR_W-1:0]          npc,
  output logic [ADDR_W-1:0]          link_pc,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       stack_full,
  output logic                       stack_empty,
  output logic                       err_mode,
  output logic                       misalign,
  output logic                       underflow
);

  localparam int unsigned DEPTH_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_W-1:0]  INC        = ADDR_W'(INST_BYTES);
  localparam logic [ADDR_W-1:0]  INC2       = ADDR_W'(2 * INST_BYTES);
  localparam logic [ADDR_W-1:0]  ALIGN_MASK = ADDR_W'(INST_BYTES - 1);
  localparam logic [ADDR_W-1:0]  RESET_NPC  = RESET_VECTOR + INC;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX  = DEPTH_W'(DEPTH);

  typedef enum logic [2:0] {
    OP_SEQ   = 3'b000,
    OP_BR    = 3'b001,
    OP_JMPL  = 3'b010,
    OP_TRAP  = 3'b011,
    OP_RETRY = 3'b100,
    OP_DONE  = 3'b101
  } op_e;

  // Architectural state
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  npc_q, npc_d;
  logic [ADDR_W-1:0]  link_q, link_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               err_q, err_d;
  logic               mis_q, mis_d;
  logic               und_q, und_d;

  // Trap stack storage: one PC array and one nPC array, indexed by depth
  logic [ADDR_W-1:0] stk_pc  [DEPTH];
  logic [ADDR_W-1:0] stk_npc [DEPTH];
  logic              push;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;
  logic [ADDR_W-1:0] top_pc;
  logic [ADDR_W-1:0] top_npc;

  // Aligned inputs and their misalignment flags
  logic [ADDR_W-1:0] target_al;
  logic [ADDR_W-1:0] vec_al;
  logic              target_mis;
  logic              vec_mis;
  logic              full;
  logic              empty;

  assign target_al  = target & ~ALIGN_MASK;
  assign vec_al     = trap_vec & ~ALIGN_MASK;
  assign target_mis = |(target & ALIGN_MASK);
  assign vec_mis    = |(trap_vec & ALIGN_MASK);

  assign full  = (depth_q == DEPTH_MAX);
  assign empty = (depth_q == '0);

  // Push lands at slot 'depth'; the top of stack lives at 'depth-1'. Both
  // truncations are safe: push only happens when not full, pop only when
  // not empty.
  assign push_idx = IDX_W'(depth_q);
  assign pop_idx  = IDX_W'(depth_q - DEPTH_W'(1));
  assign top_pc   = stk_pc[pop_idx];
  assign top_npc  = stk_npc[pop_idx];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    pc_d    = pc_q;
    npc_d   = npc_q;
    link_d  = link_q;
    depth_d = depth_q;
    err_d   = err_q;
    mis_d   = 1'b0;
    und_d   = 1'b0;
    push    = 1'b0;

    if (advance) begin
      // Sequential flow is the fallback for most ops
      pc_d  = npc_q;
      npc_d = npc_q + INC;

      unique case (op_e'(op))
        OP_BR: begin
          if (cond_taken) begin
            npc_d = target_al;
            mis_d = target_mis;
          end else if (annul) begin
            // Untaken annulled branch: skip the delay slot
            pc_d  = npc_q + INC;
            npc_d = npc_q + INC2;
          end
        end

        OP_JMPL: begin
          link_d = pc_q;
          npc_d  = target_al;
          mis_d  = target_mis;
        end

        OP_TRAP: begin
          if (!full) begin
            push    = 1'b1;
            depth_d = depth_q + DEPTH_W'(1);
            pc_d    = vec_al;
            npc_d   = vec_al + INC;
            mis_d   = vec_mis;
          end else begin
            // Nowhere to save the context: fall back to the reset vector and
            // flag the error, but keep running.
            err_d = 1'b1;
            pc_d  = RESET_VECTOR;
            npc_d = RESET_NPC;
          end
        end

        OP_RETRY: begin
          if (!empty) begin
            depth_d = depth_q - DEPTH_W'(1);
            pc_d    = top_pc;
            npc_d   = top_npc;
          end else begin
            und_d = 1'b1;
          end
        end

        OP_DONE: begin
          if (!empty) begin
            depth_d = depth_q - DEPTH_W'(1);
            pc_d    = top_npc;
            npc_d   = top_npc + INC;
          end else begin
            und_d = 1'b1;
          end
        end

        default: ; // SEQ and unused encodings: sequential flow already set
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge RESET_n) begin
    if (!RESET_n) begin
      pc_q    <= RESET_VECTOR;
      npc_q   <= RESET_NPC;
      link_q  <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      link_q  <= link_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
      und_q   <= und_d;
    end
  end

  // NOTE: the stack storage has no reset; depth alone defines which entries
  // are valid, so clearing the contents would only cost reset fan-out.
  always_ff @(posedge Clk) begin
    if (push) begin
      stk_pc[push_idx]  <= pc_q;
      stk_npc[push_idx] <= npc_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign pc          = pc_q;
  assign npc         = npc_q;
  assign link_pc     = link_q;
  assign depth       = depth_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign err_mode    = err_q;
  assign misalign    = mis_q;
  assign underflow   = und_q;

endmodule

// File: tb/tb_pc_npc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_npc_sequencer
//
// Directed scoreboard bench. Instance A uses the default parameters; instance
// B uses ADDR_W=8 with RESET_VECTOR=0xF8 to exercise address wrap. Stimulus
// pushes hand-computed expectations into a queue; a monitor pops and compares
// one entry after each rising edge (or after an asynchronous reset event).
// -----------------------------------------------------------------------------
module tb_pc_npc_sequencer;

  localparam logic [2:0] SEQ = 3'b000, BR = 3'b001, JMPL = 3'b010,
                         TRAP = 3'b011, RETRY = 3'b100, DONE = 3'b101;

  logic        Clk = 1'b0;
  logic        RESET_n = 1'b0;
  logic        advance_a = 1'b0;
  logic        advance_b = 1'b0;
  logic [2:0]  op = 3'b000;
  logic        cond_taken = 1'b0;
  logic        annul = 1'b0;
  logic [31:0] target = '0;
  logic [31:0] trap_vec = '0;

  logic [31:0] pc_a, npc_a, link_a;
  logic [2:0]  depth_a;
  logic        full_a, empty_a, err_a, mis_a, und_a;

  logic [7:0]  pc_b, npc_b, link_b;
  logic [2:0]  depth_b;
  logic        full_b, empty_b, err_b, mis_b, und_b;

  always #5 Clk = ~Clk;

  pc_npc_sequencer dut_a (
    .Clk(Clk), .RESET_n(RESET_n), .advance(advance_a), .op(op),
    .cond_taken(cond_taken), .annul(annul), .target(target), .trap_vec(trap_vec),
    .pc(pc_a), .npc(npc_a), .link_pc(link_a), .depth(depth_a),
    .stack_full(full_a), .stack_empty(empty_a), .err_mode(err_a),
    .misalign(mis_a), .underflow(und_a)
  );

  pc_npc_sequencer #(.ADDR_W(8), .RESET_VECTOR(8'hF8)) dut_b (
    .Clk(Clk), .RESET_n(RESET_n), .advance(advance_b), .op(op),
    .cond_taken(cond_taken), .annul(annul), .target(target[7:0]),
    .trap_vec(trap_vec[7:0]),
    .pc(pc_b), .npc(npc_b), .link_pc(link_b), .depth(depth_b),
    .stack_full(full_b), .stack_empty(empty_b), .err_mode(err_b),
    .misalign(mis_b), .underflow(und_b)
  );

  typedef struct {
    bit          sel;    // 0: instance A, 1: instance B
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] link;
    int          depth;
    bit          err;
    bit          mis;
    bit          und;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  event async_ev;
  int   tests = 0;
  int   fails = 0;

  // ---------------------------------------------------------------------------
  // Monitor: compare one expectation after each edge that produced one
  // ---------------------------------------------------------------------------
  initial begin : monitor
    exp_t        e;
    logic [31:0] a_pc, a_npc, a_link;
    int          a_depth;
    bit          a_full, a_empty, a_err, a_mis, a_und;
    bit          e_full, e_empty;
    forever begin
      @(posedge Clk or async_ev);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.sel) begin
          a_pc = {24'h0, pc_b}; a_npc = {24'h0, npc_b}; a_link = {24'h0, link_b};
          a_depth = int'(depth_b); a_full = full_b; a_empty = empty_b;
          a_err = err_b; a_mis = mis_b; a_und = und_b;
        end else begin
          a_pc = pc_a; a_npc = npc_a; a_link = link_a;
          a_depth = int'(depth_a); a_full = full_a; a_empty = empty_a;
          a_err = err_a; a_mis = mis_a; a_und = und_a;
        end
        e_full  = (e.depth == 4);
        e_empty = (e.depth == 0);
        tests++;
        if (a_pc !== e.pc || a_npc !== e.npc || a_link !== e.link ||
            a_depth != e.depth || a_full !== e_full || a_empty !== e_empty ||
            a_err !== e.err || a_mis !== e.mis || a_und !== e.und) begin
          fails++;
          $display("FAIL %s: got pc=%h npc=%h link=%h depth=%0d full=%b empty=%b err=%b mis=%b und=%b; expected pc=%h npc=%h link=%h depth=%0d full=%b empty=%b err=%b mis=%b und=%b",
                   e.name, a_pc, a_npc, a_link, a_depth, a_full, a_empty, a_err, a_mis, a_und,
                   e.pc, e.npc, e.link, e.depth, e_full, e_empty, e.err, e.mis, e.und);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step(input bit sel, input bit adv, input logic [2:0] o,
                      input bit ct, input bit an,
                      input logic [31:0] tgt, input logic [31:0] vec,
                      input logic [31:0] e_pc, input logic [31:0] e_npc,
                      input logic [31:0] e_link, input int e_depth,
                      input bit e_err, input bit e_mis, input bit e_und,
                      input string nm);
    exp_t e;
    @(negedge Clk);
    advance_a  = adv && !sel;
    advance_b  = adv && sel;
    op         = o;
    cond_taken = ct;
    annul      = an;
    target     = tgt;
    trap_vec   = vec;
    e.sel = sel; e.pc = e_pc; e.npc = e_npc; e.link = e_link; e.depth = e_depth;
    e.err = e_err; e.mis = e_mis; e.und = e_und; e.name = nm;
    exp_q.push_back(e);
  endtask

  // Assert reset between edges and check the outputs before the next edge
  task automatic async_reset(input string nm);
    exp_t e;
    @(negedge Clk);
    advance_a = 1'b0;
    advance_b = 1'b0;
    #2;
    RESET_n = 1'b0;
    e.sel = 1'b0; e.pc = 32'h0; e.npc = 32'h4; e.link = 32'h0; e.depth = 0;
    e.err = 1'b0; e.mis = 1'b0; e.und = 1'b0; e.name = nm;
    exp_q.push_back(e);
    -> async_ev;
    @(negedge Clk);
    RESET_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin : stimulus
    repeat (2) @(negedge Clk);
    RESET_n = 1'b1;

    //   sel adv op     ct an target        trap_vec      pc            npc           link          d  err mis und
    step(0, 0, SEQ,   0, 0, 32'h0,        32'h0,        32'h0,        32'h4,        32'h0,        0, 0, 0, 0, "reset_state");
    step(0, 1, SEQ,   0, 0, 32'h0,        32'h0,        32'h4,        32'h8,        32'h0,        0, 0, 0, 0, "seq1");
    step(0, 1, SEQ,   0, 0, 32'h0,        32'h0,        32'h8,        32'hC,        32'h0,        0, 0, 0, 0, "seq2");
    step(0, 1, SEQ,   0, 0, 32'h0,        32'h0,        32'hC,        32'h10,       32'h0,        0, 0, 0, 0, "seq3");
    async_reset("async_reset1");

    step(0, 1, SEQ,   0, 0, 32'h0,        32'h0,        32'h4,        32'h8,        32'h0,        0, 0, 0, 0, "post_reset_seq1");
    step(0, 1, SEQ,   0, 0, 32'h0,        32'h0,        32'h8,        32'hC,        32'h0,        0, 0, 0, 0, "post_reset_seq2");
    step(0, 1, BR,    1, 1, 32'h40,       32'h0,        32'hC,        32'h40,       32'h0,        0, 0, 0, 0, "br_taken");
    step(0, 1, SEQ,   0, 0, 32'h0,        32'h0,        32'h40,       32'h44,       32'h0,        0, 0, 0, 0, "br_taken_then_seq");
    async_reset("async_reset2");

    step(0, 1, SEQ,   0, 0, 32'h0,        32'h0,        32'h4,        32'h8,        32'h0,        0, 0, 0, 0, "seq_a");
    step(0, 1, SEQ,   0, 0, 32'h0,        32'h0,        32'h8,        32'hC,        32'h0,        0, 0, 0, 0, "seq_b");
    step(0, 1, BR,    0, 1, 32'h80,       32'h0,        32'h10,       32'h14,       32'h0,        0, 0, 0, 0, "br_untaken_annul");
    step(0, 1, BR,    0, 0, 32'h80,       32'h0,        32'h14,       32'h18,       32'h0,        0, 0, 0, 0, "br_untaken_noannul");
    step(0, 1, BR,    1, 0, 32'h42,       32'h0,        32'h18,       32'h40,       32'h0,        0, 0, 1, 0, "br_taken_misaligned");
    step(0, 0, BR,    1, 0, 32'h43,       32'h0,        32'h18,       32'h40,       32'h0,        0, 0, 0, 0, "hold_mis_clears");
    step(0, 1, BR,    1, 0, 32'h20,       32'h3,        32'h40,       32'h20,       32'h0,        0, 0, 0, 0, "br_taken_to_20");
    step(0, 1, SEQ,   0, 0, 32'h0,        32'h0,        32'h20,       32'h24,       32'h0,        0, 0, 0, 0, "seq_to_20");
    step(0, 1, JMPL,  0, 0, 32'h103,      32'h0,        32'h24,       32'h100,      32'h20,       0, 0, 1, 0, "jmpl_misaligned");
    step(0, 0, SEQ,   0, 0, 32'h0,        32'h0,        32'h24,       32'h100,      32'h20,       0, 0, 0, 0, "jmpl_pulse_ends");
    step(0, 1, BR,    1, 0, 32'h10,       32'h0,        32'h100,      32'h10,       32'h20,       0, 0, 0, 0, "br_taken_to_10");
    step(0, 1, SEQ,   0, 0, 32'h0,        32'h0,        32'h10,       32'h14,       32'h20,       0, 0, 0, 0, "seq_to_10");

    step(0, 1, TRAP,  0, 0, 32'h0,        32'h800,      32'h800,      32'h804,      32'h20,       1, 0, 0, 0, "trap1");
    step(0, 1, RETRY, 0, 0, 32'h0,        32'h0,        32'h10,       32'h14,       32'h20,       0, 0, 0, 0, "retry");
    step(0, 1, TRAP,  0, 0, 32'h0,        32'h800,      32'h800,      32'h804,      32'h20,       1, 0, 0, 0, "trap2");
    step(0, 1, DONE,  0, 0, 32'h0,        32'h0,        32'h14,       32'h18,       32'h20,       0, 0, 0, 0, "done");

    step(0, 1, TRAP,  0, 0, 32'h0,        32'h100,      32'h100,      32'h104,      32'h20,       1, 0, 0, 0, "nest1");
    step(0, 1, TRAP,  0, 0, 32'h0,        32'h200,      32'h200,      32'h204,      32'h20,       2, 0, 0, 0, "nest2");
    step(0, 1, TRAP,  0, 0, 32'h0,        32'h300,      32'h300,      32'h304,      32'h20,       3, 0, 0, 0, "nest3");
    step(0, 1, TRAP,  0, 0, 32'h0,        32'h400,      32'h400,      32'h404,      32'h20,       4, 0, 0, 0, "nest4_full");
    step(0, 1, TRAP,  0, 0, 32'h0,        32'h500,      32'h0,        32'h4,        32'h20,       4, 1, 0, 0, "trap_when_full");
    step(0, 1, DONE,  0, 0, 32'h0,        32'h0,        32'h304,      32'h308,      32'h20,       3, 1, 0, 0, "unnest_done1");
    step(0, 1, DONE,  0, 0, 32'h0,        32'h0,        32'h204,      32'h208,      32'h20,       2, 1, 0, 0, "unnest_done2");
    step(0, 1, DONE,  0, 0, 32'h0,        32'h0,        32'h104,      32'h108,      32'h20,       1, 1, 0, 0, "unnest_done3");
    step(0, 1, DONE,  0, 0, 32'h0,        32'h0,        32'h18,       32'h1C,       32'h20,       0, 1, 0, 0, "unnest_done4");
    step(0, 1, DONE,  0, 0, 32'h0,        32'h0,        32'h1C,       32'h20,       32'h20,       0, 1, 0, 1, "done_underflow");
    step(0, 0, DONE,  0, 0, 32'h0,        32'h0,        32'h1C,       32'h20,       32'h20,       0, 1, 0, 0, "underflow_pulse_ends");
    step(0, 1, 3'b110, 1, 1, 32'h80,      32'h80,       32'h20,       32'h24,       32'h20,       0, 1, 0, 0, "op110_as_seq");
    step(0, 1, TRAP,  0, 0, 32'h0,        32'h602,      32'h600,      32'h604,      32'h20,       1, 1, 1, 0, "trap_vec_misaligned");
    step(0, 1, RETRY, 0, 0, 32'h0,        32'h0,        32'h20,       32'h24,       32'h20,       0, 1, 0, 0, "retry_after_mis");
    step(0, 1, RETRY, 0, 0, 32'h0,        32'h0,        32'h24,       32'h28,       32'h20,       0, 1, 0, 1, "retry_underflow");

    // Instance B: 8-bit wrap, reset vector 0xF8 (untouched until now)
    step(1, 0, SEQ,   0, 0, 32'h0,        32'h0,        32'hF8,       32'hFC,       32'h0,        0, 0, 0, 0, "wrap_initial");
    step(1, 1, SEQ,   0, 0, 32'h0,        32'h0,        32'hFC,       32'h00,       32'h0,        0, 0, 0, 0, "wrap_seq1");
    step(1, 1, SEQ,   0, 0, 32'h0,        32'h0,        32'h00,       32'h04,       32'h0,        0, 0, 0, 0, "wrap_seq2");
    step(1, 0, SEQ,   0, 0, 32'h0,        32'h0,        32'h00,       32'h04,       32'h0,        0, 0, 0, 0, "wrap_hold1");
    step(1, 0, TRAP,  0, 0, 32'h0,        32'h0,        32'h00,       32'h04,       32'h0,        0, 0, 0, 0, "wrap_hold2");
    step(1, 0, JMPL,  0, 0, 32'h33,       32'h0,        32'h00,       32'h04,       32'h0,        0, 0, 0, 0, "wrap_hold3");

    @(negedge Clk);
    advance_a = 1'b0;
    advance_b = 1'b0;
    repeat (3) @(negedge Clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
